// File: rtl/jt12_pkg.sv
// Shared slot encodings and helpers for the jt12 FM core.
package jt12_pkg;

    localparam int unsigned NUM_SLOTS = 24;
    localparam int unsigned NUM_CH    = 6;
    localparam int unsigned NUM_OP    = 4;
    localparam int unsigned OP_W      = 2;
    localparam int unsigned CH_W      = 3;
    localparam int unsigned IDX_W     = 3;

    // Operator codes in slot-counter order (S1, S3, S2, S4).
    typedef enum logic [OP_W-1:0] {
        OP_S1 = 2'd0,
        OP_S3 = 2'd1,
        OP_S2 = 2'd2,
        OP_S4 = 2'd3
    } op_code_e;

    // Channel codes as written to register 0x28; 3 and 7 are holes.
    typedef enum logic [CH_W-1:0] {
        CH_1   = 3'd0,
        CH_2   = 3'd1,
        CH_3   = 3'd2,
        CH_BAD = 3'd3,
        CH_4   = 3'd4,
        CH_5   = 3'd5,
        CH_6   = 3'd6,
        CH_BD2 = 3'd7
    } ch_code_e;

    // One slot position of the operator sequencer.
    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [CH_W-1:0] ch;
    } slot_t;

    // Channel code to dense 0..5 channel index.
    function automatic logic [IDX_W-1:0] ch_index(input logic [CH_W-1:0] c);
        return c[2] ? (IDX_W'(c[1:0]) + IDX_W'(3)) : IDX_W'(c[1:0]);
    endfunction

    // Codes 3 and 7 do not address a channel.
    function automatic logic ch_valid(input logic [CH_W-1:0] c);
        return c[1:0] != 2'd3;
    endfunction

    // Operator code to keyon_op bit position (S1=0, S2=1, S3=2, S4=3).
    function automatic logic [1:0] op_bit(input logic [OP_W-1:0] op);
        logic [1:0] b;
        case (op)
            OP_S1:   b = 2'd0;
            OP_S3:   b = 2'd2;
            OP_S2:   b = 2'd1;
            default: b = 2'd3;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/jt12_slot_next.sv
// Combinational successor of the current operator slot.
module jt12_slot_next
    import jt12_pkg::*;
(
    input  logic [OP_W-1:0] cur_op,
    input  logic [CH_W-1:0] cur_ch,
    output logic [OP_W-1:0] next_op_c,
    output logic [CH_W-1:0] next_ch_c
);

    // Channels run 0,1,2,4,5,6; the operator advances after channel 6.
    always_comb begin
        next_ch_c = cur_ch + CH_W'(1);
        next_op_c = cur_op;
        if (cur_ch[1:0] == 2'd2) begin
            next_ch_c = cur_ch + CH_W'(2);
        end
        if (cur_ch == CH_6) begin
            next_op_c = cur_op + OP_W'(1);
        end
    end

endmodule

// File: rtl/jt12_keyon_ctrl.sv
// Key-on state for all 24 operator slots, with CSM key-on of channel 3.
module jt12_keyon_ctrl
    import jt12_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic [3:0]      keyon_op,
    input  logic [CH_W-1:0] keyon_ch,
    input  logic [OP_W-1:0] cur_op,
    input  logic [CH_W-1:0] cur_ch,
    input  logic            up_keyon,
    input  logic            csm,
    input  logic            overflow_A,
    output logic            keyon_I
);

    logic [NUM_CH-1:0][NUM_OP-1:0] kon;
    logic                          csm_pend;
    slot_t                         csm_slot;
    slot_t                         cur_slot;

    logic [OP_W-1:0]  next_op;
    logic [CH_W-1:0]  next_ch;
    logic             wr_valid_c;
    logic [IDX_W-1:0] wr_idx_c;
    logic [IDX_W-1:0] nxt_idx_c;
    logic [1:0]       nxt_bit_c;
    logic             kon_nxt_c;
    logic             csm_hit_c;

    jt12_slot_next u_slot_next (
        .cur_op    (cur_op),
        .cur_ch    (cur_ch),
        .next_op_c (next_op),
        .next_ch_c (next_ch)
    );

    // Decode the write target and the next slot's key-on bit, write-first.
    always_comb begin
        cur_slot   = '{op: cur_op, ch: cur_ch};
        wr_valid_c = up_keyon & ch_valid(keyon_ch);
        wr_idx_c   = ch_index(keyon_ch);
        nxt_idx_c  = ch_index(next_ch);
        nxt_bit_c  = op_bit(next_op);
        kon_nxt_c  = kon[nxt_idx_c][nxt_bit_c];
        if (wr_valid_c && (wr_idx_c == nxt_idx_c)) begin
            kon_nxt_c = keyon_op[nxt_bit_c];
        end
        csm_hit_c = csm & csm_pend & (next_ch == CH_3);
    end

    // Register 0x28 writes replace all four operator bits of one channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            kon <= '0;
        end else if (clk_en && wr_valid_c) begin
            kon[wr_idx_c] <= keyon_op;
        end
    end

    // Timer A overflow holds CSM key-on for one full slot rotation.
    always_ff @(posedge clk) begin
        if (rst) begin
            csm_pend <= 1'b0;
            csm_slot <= '0;
        end else if (clk_en) begin
            if (overflow_A) begin
                csm_pend <= 1'b1;
                csm_slot <= cur_slot;
            end else if (csm_pend && (cur_slot == csm_slot)) begin
                csm_pend <= 1'b0;
            end
        end
    end

    // Present the next slot's key-on one stage ahead of the slot counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            keyon_I <= 1'b0;
        end else if (clk_en) begin
            keyon_I <= kon_nxt_c | csm_hit_c;
        end
    end

endmodule

// File: tb/tb_jt12_keyon_ctrl.sv
// Directed self-checking bench for jt12_keyon_ctrl.
module tb_jt12_keyon_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic [3:0] keyon_op = 4'd0;
    logic [2:0] keyon_ch = 3'd0;
    logic [1:0] cur_op = 2'd0;
    logic [2:0] cur_ch = 3'd0;
    logic       up_keyon = 1'b0;
    logic       csm = 1'b0;
    logic       overflow_A = 1'b0;
    logic       keyon_I;

    int tests = 0;
    int fails = 0;

    // Bench view of the slot order and encodings.
    logic [2:0] chtab [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    int         idx_tab [8] = '{0, 1, 2, -1, 3, 4, 5, -1};
    int         bit_tab [4] = '{0, 2, 1, 3};

    logic [3:0] kon_m [6];
    int         pos = 0;
    int         csm_left = 0;
    int         ones = 0;
    logic       last_exp = 1'b0;

    jt12_keyon_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .keyon_op   (keyon_op),
        .keyon_ch   (keyon_ch),
        .cur_op     (cur_op),
        .cur_ch     (cur_ch),
        .up_keyon   (up_keyon),
        .csm        (csm),
        .overflow_A (overflow_A),
        .keyon_I    (keyon_I)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s pos=%0d op=%0d ch=%0d: keyon_I=%0b expected %0b",
                   tag, pos, cur_op, cur_ch, got, want);
        end
    endtask

    // One clk_en slot: optional write/overflow at this edge, then check new slot.
    task automatic step(input logic wr, input logic [2:0] wch,
                        input logic [3:0] wop, input logic ovf);
        logic e;
        int   ix;
        up_keyon   = wr;
        keyon_ch   = wch;
        keyon_op   = wop;
        overflow_A = ovf;
        @(posedge clk);
        #1;
        if (wr && idx_tab[wch] >= 0) kon_m[idx_tab[wch]] = wop;
        pos        = (pos + 1) % 24;
        cur_op     = 2'(pos / 6);
        cur_ch     = chtab[pos % 6];
        up_keyon   = 1'b0;
        overflow_A = 1'b0;
        ix = idx_tab[cur_ch];
        e  = kon_m[ix][bit_tab[cur_op]] | (csm && csm_left > 0 && cur_ch == 3'd2);
        if (csm_left > 0) csm_left--;
        if (ovf) csm_left = 24;
        last_exp = e;
        if (keyon_I === 1'b1) ones++;
        check("slot", keyon_I, e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 4'd0, 1'b0);
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < 24 && pos != p; i++) step(1'b0, 3'd0, 4'd0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) kon_m[i] = 4'd0;

        // Reset with clk_en low still clears the output.
        repeat (3) @(posedge clk);
        #1;
        check("reset", keyon_I, 1'b0);
        rst    = 1'b0;
        clk_en = 1'b1;

        // Idle rotation after reset.
        run(48);

        // ch4 key-on of S1 and S3 only.
        step(1'b1, 3'd4, 4'b0101, 1'b0);
        ones = 0;
        run(24);
        tests++;
        assert (ones == 2) else begin
            fails++;
            $error("FAIL ch4_count: ones=%0d expected 2", ones);
        end

        // Invalid channel codes are ignored.
        step(1'b1, 3'd3, 4'hF, 1'b0);
        step(1'b1, 3'd7, 4'hF, 1'b0);
        run(24);

        // ch2 on, then off.
        step(1'b1, 3'd1, 4'hF, 1'b0);
        run(24);
        step(1'b1, 3'd1, 4'h0, 1'b0);
        run(24);

        // CSM: overflow at (S2,ch5) keys ch3 for one rotation.
        csm = 1'b1;
        run_to(16);
        step(1'b0, 3'd0, 4'd0, 1'b1);
        ones = 0;
        run(24);
        tests++;
        assert (ones == 6) else begin
            fails++;
            $error("FAIL csm_count: ones=%0d expected 6", ones);
        end
        run(12);

        // Overflow with csm off contributes nothing.
        csm = 1'b0;
        run_to(16);
        step(1'b0, 3'd0, 4'd0, 1'b1);
        run(30);

        // csm drop mid-window masks immediately.
        csm = 1'b1;
        run_to(16);
        step(1'b0, 3'd0, 4'd0, 1'b1);
        run(10);
        csm = 1'b0;
        run(20);

        // Write-first: write ch3 S1 while the next slot is (S1,ch3).
        run_to(1);
        step(1'b1, 3'd2, 4'b0001, 1'b0);
        check("write_first", keyon_I, 1'b1);
        run(24);

        // clk_en low: hold output and ignore strobes.
        clk_en     = 1'b0;
        up_keyon   = 1'b1;
        keyon_ch   = 3'd0;
        keyon_op   = 4'hF;
        overflow_A = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold", keyon_I, last_exp);
        end
        up_keyon   = 1'b0;
        overflow_A = 1'b0;
        clk_en     = 1'b1;
        csm        = 1'b1;
        run(24);
        csm = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
